// File: rtl/priority_decoder_stream_pkg.sv
// Shared types and helpers for the priority encoder/decoder pair.
// Holds the default index width, the {idle, code} word and the one-hot helper.
package priority_codec_pkg;

    localparam int CODE_W = 3;

    typedef struct packed {
        logic              idle;
        logic [CODE_W-1:0] code;
    } word_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fifo_state_e;

    function automatic logic [2**CODE_W-1:0] onehot_of(input logic [CODE_W-1:0] code);
        logic [2**CODE_W-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/priority_decoder_stream_if.sv
// Stream bundle between encoder-side producer, decoder and consumer.
// slave is the decoder's view, master is the driving/observing side.
interface priority_decoder_stream_if #(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) ();
    localparam int OW = 2**CODE_W;
    localparam int LW = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [CODE_W-1:0] in_code;
    logic              in_idle;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_onehot;
    logic              out_idle;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  count;
    logic              err;

    modport slave (
        input  in_valid, in_code, in_idle, out_ready,
        output in_ready, out_valid, out_onehot, out_idle, level, count, err
    );

    modport master (
        output in_valid, in_code, in_idle, out_ready,
        input  in_ready, out_valid, out_onehot, out_idle, level, count, err
    );

endinterface

// File: rtl/priority_decoder_stream_sync_fifo_ptr.sv
// Small synchronous FIFO: storage, wrapping pointers, occupancy and state.
// Push ignored when full (even with a same-cycle pop), pop ignored when empty.
module sync_fifo_ptr
    import priority_codec_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [DW-1:0]              i_din,
    input  logic                       i_pop,
    output logic [DW-1:0]              o_dout,
    output logic                       o_pop_fire,
    output logic [$clog2(DEPTH):0]     o_level,
    output fifo_state_e                o_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

    always_comb begin
        o_state = ST_PARTIAL;
        if (w_empty)     o_state = ST_EMPTY;
        else if (w_full) o_state = ST_FULL;
    end

    assign o_dout     = r_mem[r_rd_ptr];
    assign o_pop_fire = w_pop;
    assign o_level    = r_level;

endmodule

// File: rtl/priority_decoder_stream.sv
// Buffers encoded {idle, code} words and replays them as one-hot vectors; 1-cycle latency, no bypass.
// Stalls the producer only when the FIFO is full; counts delivered non-idle words (saturating).
// Optional malformed-word check (idle with nonzero code) built when DEC_CHECK_EN is defined.
module priority_decoder_stream
    import priority_codec_pkg::*;
#(
    parameter int CODE_W = 3,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    priority_decoder_stream_if.slave bus
);
    localparam int OW = 2**CODE_W;
    localparam int DW = CODE_W + 1;

    logic [DW-1:0]        w_head;
    logic                 w_pop_fire;
    logic [OW-1:0]        w_dec;
    logic                 w_head_idle;
    fifo_state_e          w_state;
    logic [CNT_W-1:0]     r_count;

    sync_fifo_ptr #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (bus.in_valid),
        .i_din      ({bus.in_idle, bus.in_code}),
        .i_pop      (bus.out_ready),
        .o_dout     (w_head),
        .o_pop_fire (w_pop_fire),
        .o_level    (bus.level),
        .o_state    (w_state)
    );

    assign w_head_idle = w_head[DW-1];

    generate
        if (CODE_W == priority_codec_pkg::CODE_W) begin : g_pkg_dec
            word_t w_word;
            assign w_word = word_t'(w_head);
            assign w_dec  = onehot_of(w_word.code);
        end else begin : g_gen_dec
            assign w_dec = OW'(1) << w_head[CODE_W-1:0];
        end
    endgenerate

    assign bus.in_ready   = (w_state != ST_FULL);
    assign bus.out_valid  = (w_state != ST_EMPTY);
    assign bus.out_onehot = (bus.out_valid && !w_head_idle) ? w_dec : '0;
    assign bus.out_idle   = bus.out_valid && w_head_idle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_pop_fire && !w_head_idle && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.count = r_count;

`ifdef DEC_CHECK_EN
    logic w_push_fire;
    logic r_err;

    assign w_push_fire = bus.in_valid && bus.in_ready;

    // The encoder always drives code 0 alongside idle; anything else is a broken upstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_push_fire && bus.in_idle && (bus.in_code != '0)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_priority_decoder_stream.sv
// Scoreboard bench for priority_decoder_stream (DEPTH=4, narrow counter to reach saturation quickly).
module tb_priority_decoder_stream;

    localparam int CODE_W = 3;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 4;

    typedef struct packed {
        logic [7:0] oh;
        logic       idl;
    } exp_t;

    logic clk;
    logic rst;

    priority_decoder_stream_if #(.CODE_W(CODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    priority_decoder_stream #(.CODE_W(CODE_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int             checks   = 0;
    int             failures = 0;
    exp_t           sb_q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic [7:0]     oh_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

`ifdef DEC_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_idle   = 1'b0;
        bus.out_ready = 1'b0;
        sb_q.delete();
        exp_cnt = '0;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic push(input logic [2:0] c, input logic idl, input logic [7:0] oh);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        bus.in_idle  = idl;
        while (!bus.in_ready && n < 20) begin
            cyc();
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=in_ready_low required=in_ready_high");
        end else begin
            sb_q.push_back('{oh: oh, idl: idl});
            cyc();
        end
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every accepted head is compared against the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected actual=onehot_%0h required=no_word", bus.out_onehot);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_onehot", 32'(bus.out_onehot), 32'(e.oh));
                    chk("sb_idle", 32'(bus.out_idle), 32'(e.idl));
                    if (!e.idl && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
                end
            end
        end
    end

    initial begin
        logic [2:0] c;
        logic       idl;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_code   = '0;
        bus.in_idle   = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_onehot", 32'(bus.out_onehot), 32'd0);
        chk("rst_out_idle", 32'(bus.out_idle), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        do_reset();

        // Single word, consumer stalled then pops.
        push(3'b101, 1'b0, 8'b0010_0000);
        chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_onehot", 32'(bus.out_onehot), 32'h20);
        chk("t1_level", 32'(bus.level), 32'd1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t1_count", 32'(bus.count), 32'd1);
        chk("t1_out_valid_after", 32'(bus.out_valid), 32'd0);

        // Fill to DEPTH, attempt a fifth push, then drain.
        do_reset();
        push(3'd0, 1'b0, 8'h01);
        push(3'd7, 1'b0, 8'h80);
        push(3'd2, 1'b0, 8'h04);
        push(3'd0, 1'b1, 8'h00);
        chk("t2_level_full", 32'(bus.level), 32'd4);
        chk("t2_in_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_code  = 3'd1;
        bus.in_idle  = 1'b0;
        cyc();
        cyc();
        chk("t2_level_ignored", 32'(bus.level), 32'd4);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cyc();
        bus.out_ready = 1'b0;
        chk("t2_count", 32'(bus.count), 32'd3);
        chk("t2_level_empty", 32'(bus.level), 32'd0);
        chk("t2_out_valid", 32'(bus.out_valid), 32'd0);

        // Continuous push+pop at level 2 across pointer wrap.
        do_reset();
        push(3'd1, 1'b0, 8'h02);
        push(3'd6, 1'b0, 8'h40);
        chk("t3_level_start", 32'(bus.level), 32'd2);
        for (int i = 0; i < 20; i++) begin
            idl = (i % 5 == 4);
            c   = idl ? 3'd0 : 3'(i);
            bus.in_valid  = 1'b1;
            bus.in_code   = c;
            bus.in_idle   = idl;
            bus.out_ready = 1'b1;
            sb_q.push_back('{oh: (idl ? 8'h00 : oh_tab[c]), idl: idl});
            cyc();
            chk("t3_level_steady", 32'(bus.level), 32'd2);
        end
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        bus.out_ready = 1'b0;
        chk("t3_level_drained", 32'(bus.level), 32'd0);
        chk("t3_count", 32'(bus.count), 32'(exp_cnt));

        // Saturating counter: 14 words reach 4'hE, three more stop at 4'hF.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 14; i++) push(3'(i), 1'b0, oh_tab[i % 8]);
        cyc();
        chk("t4_count_e", 32'(bus.count), 32'hE);
        push(3'd4, 1'b0, 8'h10);
        cyc();
        chk("t4_count_f", 32'(bus.count), 32'hF);
        push(3'd5, 1'b0, 8'h20);
        push(3'd6, 1'b0, 8'h40);
        cyc();
        chk("t4_count_sat", 32'(bus.count), 32'hF);
        bus.out_ready = 1'b0;

        // Asynchronous reset with three words buffered.
        do_reset();
        bus.out_ready = 1'b1;
        push(3'd3, 1'b0, 8'h08);
        cyc();
        bus.out_ready = 1'b0;
        push(3'd1, 1'b0, 8'h02);
        push(3'd2, 1'b0, 8'h04);
        push(3'd7, 1'b0, 8'h80);
        chk("t5_level_pre", 32'(bus.level), 32'd3);
        chk("t5_count_pre", 32'(bus.count), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
        chk("t5_onehot", 32'(bus.out_onehot), 32'd0);
        chk("t5_level", 32'(bus.level), 32'd0);
        chk("t5_count", 32'(bus.count), 32'd0);
        chk("t5_in_ready", 32'(bus.in_ready), 32'd1);
        do_reset();

        // Malformed idle word.
        chk("t6_err_before", 32'(bus.err), 32'd0);
        push(3'b011, 1'b1, 8'h00);
        chk("t6_err", 32'(bus.err), 32'(EXP_ERR));
        chk("t6_onehot", 32'(bus.out_onehot), 32'd0);
        chk("t6_out_idle", 32'(bus.out_idle), 32'd1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        chk("t6_err_sticky", 32'(bus.err), 32'(EXP_ERR));
        chk("t6_count", 32'(bus.count), 32'd0);

        cyc();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/priority_decoder_stream.md
Name: priority_decoder_stream

Overview:
- Inverse of the 8-to-3 priority encoder.
- Accepts a stream of encoded words {idle, code} over a valid/ready handshake and buffers them in a small FIFO.
- Presents each word as a one-hot vector with a separate idle flag, and keeps a saturating count of decoded non-idle words.
- Sits downstream of the priority encoder; lets a consumer rebuild the winning request line at its own pace.

Parameters:
- CODE_W, 3, width of the encoded index; output width is 2**CODE_W (8 by default).
- DEPTH, 4, FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the decoded-event counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept; equals !full.
- in_code  input  CODE_W  encoded index.
- in_idle  input  1  encoder IDLE flag (no request active).
- out_valid  output  1  FIFO head available; equals !empty.
- out_ready  input  1  consumer accepts head.
- out_onehot  output  2**CODE_W  decoded head: bit[code]=1 when !idle; all zeros when idle.
- out_idle  output  1  idle flag of the head.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- count  output  CNT_W  number of non-idle words delivered.
- err  output  1  sticky malformed-word flag (see Optional Feature).

Behaviour:
- Reset (async assert, released synchronously to clk):
  - wr_ptr = rd_ptr = 0, level = 0, count = 0, err = 0.
  - in_ready = 1, out_valid = 0, out_onehot = 0, out_idle = 0.
  - Reset mid-operation discards all buffered words immediately.
- Push: in_valid && in_ready at a rising edge writes {in_idle, in_code} to mem[wr_ptr]; wr_ptr increments and wraps modulo DEPTH.
- Pop: out_valid && out_ready at a rising edge increments rd_ptr, wrapping modulo DEPTH.
- Outputs are decoded combinationally from mem[rd_ptr]:
  - out_onehot = out_valid && !idle ? (1 << code) : 0.
  - out_idle = out_valid && idle.
- Latency: a word accepted at edge N is visible on out_* after edge N (one cycle).
- Full: in_ready = 0 when level == DEPTH, even if a pop occurs in the same cycle (no pass-through on full). in_* is ignored while in_ready = 0.
- Empty: out_valid = 0 and outputs are zero. A push into an empty FIFO appears next cycle (no bypass).
- Simultaneous push and pop when 0 < level < DEPTH: level is unchanged, both pointers advance.
- Producer must hold in_code/in_idle stable while in_valid && !in_ready. The consumer sees the head stable while out_valid && !out_ready.
- count increments by 1 on each pop with idle = 0 and saturates at all-ones (no wrap). Idle words do not count.
- FSM view (derived from level, no separate state register):
  - EMPTY → PARTIAL on push.
  - PARTIAL → FULL on push-only reaching DEPTH.
  - PARTIAL → EMPTY on pop-only reaching 0.
  - FULL → PARTIAL on pop.

Optional Feature:
- Macro: DEC_CHECK_EN.
- Defined:
  - A word pushed with in_idle = 1 and in_code ≠ 0 is malformed, because the encoder drives 0 when idle.
  - err sets on the push edge of a malformed word and stays set until rst.
  - The word is still stored and decoded as idle.
- Undefined: no check logic is built and err is tied to 0.

Decomposition:
- Package priority_codec_pkg:
  - CODE_W default.
  - Word struct/typedef {idle, code}.
  - Function onehot_of(code), shared with encoder benches.
- One natural sub-module: sync_fifo_ptr holds the pointers, level and full/empty logic, parameterised by DEPTH and data width.
- Decode, counter and check logic stay in the top module.

Test Plan:
- After rst, push code=3'b101, idle=0 with out_ready=0 → next cycle out_valid=1, out_onehot=8'b0010_0000, level=1. Pop → count=1, out_valid=0.
- Push 4 words (codes 0,7,2 and one idle) with out_ready=0 → in_ready=0 at level=4, and a 5th push is ignored. Pop all → onehots 01,80,04,00 in order; out_idle=1 on the last; count=3.
- Hold in_valid=out_ready=1 continuously with level=2 → level stays 2 and one word moves in and one out per cycle; pointers wrap past DEPTH-1 with no corruption over 20 words.
- Preload count to 16'hFFFE via traffic (or force) and pop 3 non-idle words → count stays 16'hFFFF.
- Assert rst mid-burst with level=3 → out_valid, out_onehot, level and count are 0 immediately, in_ready=1.
- With DEC_CHECK_EN, push idle=1, code=3'b011 → err=1 from the next cycle and the word decodes to onehot 0 with out_idle=1. Without DEC_CHECK_EN the same push leaves err=0.
